alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Hardware driver for the ALU datapath (`main`). It sits upstream of the ALU and replaces the hand-written stimulus sequence from simulation. It accepts operand/operation commands over a valid/ready interface and buffers them in a small FIFO. For each command it drives the ALU's load/persist protocol, waits the ALU latency, and returns the captured result over a second valid/ready interface.

## Interface
- `WIDTH`, 8: operand/result width.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `ALU_LAT`, 2: cycles in WAIT before `alu_out` is sampled; ≥1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals `!full`.
- `cmd_op` in 3: operation index 0–6; 7 is illegal.
- `cmd_a`, `cmd_b` in WIDTH: operands.
- `alu_on` out 1: ALU enable.
- `alu_in_sel` out 3: {persist, load, reset} to ALU.
- `alu_num1`, `alu_num2` out WIDTH: operands to ALU.
- `alu_out_sel` out 7: one-hot operation select, `1 << op`.
- `alu_out` in WIDTH: ALU result.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_data` out WIDTH: captured result.
- `rsp_op` out 3: op of the returned command.
- `rsp_err` out 1: command had an illegal op.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- **FIFO:** `DEPTH` entries of {op, a, b}; push on `cmd_valid && cmd_ready`. There is no fall-through: a pushed entry is visible to the FSM one edge later. Push while full is impossible because `cmd_ready` is low.
- **FSM (IDLE, ISSUE, WAIT, HOLD):**
  - IDLE: `alu_in_sel` = 000. If the FIFO is non-empty, pop into the operand/op registers.
    - Legal op → ISSUE.
    - op==7 → HOLD, with `rsp_err`=1, `rsp_data`=0, and no ALU traffic.
  - ISSUE (1 cycle): `alu_in_sel` = 010 (load); `alu_num1`/`alu_num2`/`alu_out_sel` driven from registers. Next state WAIT; the wait counter loads `ALU_LAT`-1.
  - WAIT: `alu_in_sel` = 100 (persist); operands and select held. When the counter is 0, capture `alu_out` into `rsp_data`, set `rsp_valid` and → HOLD; otherwise decrement.
  - HOLD: `rsp_valid`=1; `rsp_data`, `rsp_op` and `rsp_err` stable. `alu_in_sel` = 100. On `rsp_valid && rsp_ready` → IDLE and clear `rsp_valid`.
- `alu_on` goes 1 at the first edge after reset release and stays 1.
- A push and a pop on the same edge are both performed; the count is unchanged.
- Reset mid-operation: the FIFO is emptied, the FSM goes to IDLE, and any in-flight command is dropped with no response.

## Timing
- Reset values:
  - `cmd_ready`=1
  - `alu_on`=0
  - `alu_in_sel`=000
  - `alu_num1`=`alu_num2`=0
  - `alu_out_sel`=0
  - `rsp_valid`=0, `rsp_data`=0, `rsp_op`=0, `rsp_err`=0
  - `busy`=0
- Legal command accepted at edge E0, with the FSM IDLE and the FIFO empty:
  - pop at E1
  - load cycle between E1 and E2
  - `alu_out` sampled at E(2+`ALU_LAT`)
  - `rsp_valid` high after that edge: 4 edges at the default.
- Illegal command: `rsp_valid` high after E2.
- Back-to-back throughput: one command per `ALU_LAT`+3 cycles with `rsp_ready` tied high.
- `cmd_ready` is registered from the FIFO count; it deasserts on the edge the FIFO becomes full.

## Configuration
- **`ALU_SEQ_STATS_EN` defined:**
  - Adds output `rsp_count` (8 bits, reset 0).
  - Increments on each `rsp_valid && rsp_ready` handshake, illegal ops included.
  - Saturates at 255.
- **Not defined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Single add:** a=0x57, b=0x1A, op=3 → `alu_out_sel`=0001000 and `alu_in_sel`=010 for one cycle, then 100. Bench ALU model returns 0x71; `rsp_data`=0x71 and `rsp_valid` are asserted 4 edges after acceptance.
- **Fill FIFO:** hold `rsp_ready`=0 and push 5 commands → `cmd_ready` drops after the 5th accepted. The 5th is accepted because the FSM popped one entry. The 6th stalls until the first response handshake.
- **Illegal op:** op=7, a=0x00, b=0x01 → `rsp_err`=1, `rsp_data`=0x00 after 2 edges. `alu_in_sel` never equals 010.
- **Backpressure:** `rsp_ready`=0 for 10 cycles → `rsp_data`/`rsp_op` stable, the FSM stays in HOLD, and the next command is not issued until the handshake.
- **Reset in WAIT:** assert `rst`=0 mid-WAIT → all outputs go to reset values immediately (asynchronously), with no response for the dropped command. A new command after release completes normally.
- **Stats (with `ALU_SEQ_STATS_EN`):** 300 handshakes → `rsp_count`=255.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO plus load/persist sequencer driving the ALU datapath
// Defining ALU_SEQ_STATS_EN adds the saturating rsp_count handshake counter.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             alu_on,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_op,
    output logic             rsp_err,
`ifdef ALU_SEQ_STATS_EN
    output logic [7:0]       rsp_count,
`endif
    output logic             busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [2:0] SEL_NONE    = 3'b000;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_PERSIST = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    cmd_t             head;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             push, pop;

    state_t           state_q, state_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic [2:0]       op_q, op_d;
    logic             alu_on_q, alu_on_d;
    logic [2:0]       alu_in_sel_q, alu_in_sel_d;
    logic [WIDTH-1:0] alu_num1_q, alu_num1_d;
    logic [WIDTH-1:0] alu_num2_q, alu_num2_d;
    logic [6:0]       alu_out_sel_q, alu_out_sel_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic             rsp_err_q, rsp_err_d;

    assign push = cmd_valid && cmd_ready_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Registered from the next count so ready falls on the very edge that fills the FIFO.
        cmd_ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        illegal_d     = illegal_q;
        op_d          = op_q;
        alu_on_d      = 1'b1;
        alu_in_sel_d  = alu_in_sel_q;
        alu_num1_d    = alu_num1_q;
        alu_num2_d    = alu_num2_q;
        alu_out_sel_d = alu_out_sel_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_op_d      = rsp_op_q;
        rsp_err_d     = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                alu_in_sel_d = SEL_NONE;
                if (pop) begin
                    op_d    = head.op;
                    state_d = S_ISSUE;
                    // Illegal ops still spend one ISSUE cycle but never touch the ALU.
                    if (head.op == 3'd7) begin
                        illegal_d = 1'b1;
                    end else begin
                        illegal_d     = 1'b0;
                        alu_in_sel_d  = SEL_LOAD;
                        alu_num1_d    = head.a;
                        alu_num2_d    = head.b;
                        alu_out_sel_d = 7'b1 << head.op;
                    end
                end
            end
            S_ISSUE: begin
                if (illegal_q) begin
                    state_d     = S_HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_op_d    = op_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d      = S_WAIT;
                    alu_in_sel_d = SEL_PERSIST;
                    cnt_d        = LW'(ALU_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_out;
                    rsp_op_d    = op_q;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            S_HOLD: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b0;
                    alu_in_sel_d = SEL_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            illegal_q     <= 1'b0;
            op_q          <= '0;
            alu_on_q      <= 1'b0;
            alu_in_sel_q  <= SEL_NONE;
            alu_num1_q    <= '0;
            alu_num2_q    <= '0;
            alu_out_sel_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_op_q      <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            illegal_q     <= illegal_d;
            op_q          <= op_d;
            alu_on_q      <= alu_on_d;
            alu_in_sel_q  <= alu_in_sel_d;
            alu_num1_q    <= alu_num1_d;
            alu_num2_q    <= alu_num2_d;
            alu_out_sel_q <= alu_out_sel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_op_q      <= rsp_op_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [7:0] rsp_count_q, rsp_count_d;

    always_comb begin
        rsp_count_d = rsp_count_q;
        if (rsp_valid_q && rsp_ready && (rsp_count_q != 8'hFF))
            rsp_count_d = rsp_count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rsp_count_q <= '0;
        else      rsp_count_q <= rsp_count_d;
    end

    assign rsp_count = rsp_count_q;
`endif

    assign cmd_ready   = cmd_ready_q;
    assign alu_on      = alu_on_q;
    assign alu_in_sel  = alu_in_sel_q;
    assign alu_num1    = alu_num1_q;
    assign alu_num2    = alu_num2_q;
    assign alu_out_sel = alu_out_sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer with a behavioural ALU
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic       alu_on;
    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1, alu_num2;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [2:0] rsp_op;
    logic       rsp_err;
    logic       busy;
`ifdef ALU_SEQ_STATS_EN
    logic [7:0] rsp_count;
`endif

    int checks = 0;
    int errors = 0;
    int load_count = 0;

    logic [2:0] f_op [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [7:0] f_a  [6] = '{8'hF0, 8'hF0, 8'hAA, 8'h10, 8'h0F, 8'h00};
    logic [7:0] f_b  [6] = '{8'h3C, 8'h0F, 8'hFF, 8'h01, 8'h00, 8'h99};
    logic [7:0] f_r  [6] = '{8'h30, 8'hFF, 8'h55, 8'h0F, 8'hF0, 8'h99};

    alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4), .ALU_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_on(alu_on), .alu_in_sel(alu_in_sel),
        .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_out_sel(alu_out_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
`ifdef ALU_SEQ_STATS_EN
        .rsp_count(rsp_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: operands latched on a load edge, result combinational.
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    logic [6:0] m_sel = 7'h00;
    always @(posedge clk) begin
        if (alu_in_sel == 3'b010) begin
            m_a   <= alu_num1;
            m_b   <= alu_num2;
            m_sel <= alu_out_sel;
        end
    end
    always_comb begin
        case (m_sel)
            7'b0000001: alu_out = m_a & m_b;
            7'b0000010: alu_out = m_a | m_b;
            7'b0000100: alu_out = m_a ^ m_b;
            7'b0001000: alu_out = m_a + m_b;
            7'b0010000: alu_out = m_a - m_b;
            7'b0100000: alu_out = ~m_a;
            7'b1000000: alu_out = m_b;
            default:    alu_out = 8'h00;
        endcase
    end

    always @(negedge clk) begin
        if (alu_in_sel == 3'b010) load_count <= load_count + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string t);
        check({t, "_cmd_ready"}, cmd_ready, 1);
        check({t, "_alu_on"}, alu_on, 0);
        check({t, "_alu_in_sel"}, alu_in_sel, 0);
        check({t, "_alu_num1"}, alu_num1, 0);
        check({t, "_alu_num2"}, alu_num2, 0);
        check({t, "_alu_out_sel"}, alu_out_sel, 0);
        check({t, "_rsp_valid"}, rsp_valid, 0);
        check({t, "_rsp_data"}, rsp_data, 0);
        check({t, "_rsp_op"}, rsp_op, 0);
        check({t, "_rsp_err"}, rsp_err, 0);
        check({t, "_busy"}, busy, 0);
`ifdef ALU_SEQ_STATS_EN
        check({t, "_rsp_count"}, rsp_count, 0);
`endif
    endtask

    task automatic wait_rsp(input int max_cyc, output int waited);
        waited = 0;
        while (!rsp_valid && waited < max_cyc) begin
            tick();
            waited++;
        end
        check("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hs_clear", rsp_valid, 0);
    endtask

    initial begin
        int waited;
        int loads0;

        // Power-on reset
        #1 rst = 1'b0;
        #1 check_reset("por");
        tick();
        tick();
        rst = 1'b1;
        check("alu_on_before_edge", alu_on, 0);
        tick();
        check("alu_on_after_edge", alu_on, 1);

        // Single add: 0x57 + 0x1A
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 8'h57; cmd_b = 8'h1A;
        check("add_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("add_e0_busy", busy, 1);
        check("add_e0_in_sel", alu_in_sel, 3'b000);
        tick();
        check("add_e1_in_sel", alu_in_sel, 3'b010);
        check("add_e1_out_sel", alu_out_sel, 7'b0001000);
        check("add_e1_num1", alu_num1, 8'h57);
        check("add_e1_num2", alu_num2, 8'h1A);
        tick();
        check("add_e2_in_sel", alu_in_sel, 3'b100);
        check("add_e2_valid", rsp_valid, 0);
        tick();
        check("add_e3_valid", rsp_valid, 0);
        tick();
        check("add_e4_valid", rsp_valid, 1);
        check("add_e4_data", rsp_data, 8'h71);
        check("add_e4_op", rsp_op, 3'd3);
        check("add_e4_err", rsp_err, 0);

        // Backpressure with a second command queued behind the held response
        loads0 = load_count;
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'h20; cmd_b = 8'h05;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 8'h71);
            check("bp_op", rsp_op, 3'd3);
            check("bp_in_sel", alu_in_sel, 3'b100);
        end
        check("bp_no_issue", load_count, loads0);
        handshake();
        tick();
        check("bp_next_in_sel", alu_in_sel, 3'b010);
        check("bp_next_num1", alu_num1, 8'h20);
        wait_rsp(10, waited);
        check("sub_data", rsp_data, 8'h1B);
        check("sub_op", rsp_op, 3'd4);
        handshake();

        // Illegal op
        loads0 = load_count;
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 8'h00; cmd_b = 8'h01;
        tick();
        cmd_valid = 1'b0;
        check("ill_e0_valid", rsp_valid, 0);
        tick();
        check("ill_e1_valid", rsp_valid, 0);
        tick();
        check("ill_e2_valid", rsp_valid, 1);
        check("ill_e2_err", rsp_err, 1);
        check("ill_e2_data", rsp_data, 8'h00);
        check("ill_e2_op", rsp_op, 3'd7);
        handshake();
        check("ill_no_load", load_count, loads0);

        // Fill the FIFO while the first response is held
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = f_op[i]; cmd_a = f_a[i]; cmd_b = f_b[i];
            check($sformatf("fill_ready%0d", i), cmd_ready, 1);
            tick();
        end
        check("fill_full", cmd_ready, 0);
        cmd_op = f_op[5]; cmd_a = f_a[5]; cmd_b = f_b[5];
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fill_stall", cmd_ready, 0);
        end
        check("fill_first_valid", rsp_valid, 1);
        check("fill_first_data", rsp_data, f_r[0]);
        check("fill_first_op", rsp_op, f_op[0]);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("fill_hs_ready", cmd_ready, 0);
        tick();
        check("fill_pop_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("fill_refull", cmd_ready, 0);

        // Drain with rsp_ready high: one response every ALU_LAT+3 cycles
        rsp_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            wait_rsp(12, waited);
            if (i >= 2) check($sformatf("thru%0d", i), waited, 4);
            check($sformatf("drain_data%0d", i), rsp_data, f_r[i]);
            check($sformatf("drain_op%0d", i), rsp_op, f_op[i]);
            check($sformatf("drain_err%0d", i), rsp_err, 0);
            tick();
        end
        rsp_ready = 1'b0;
        check("drain_idle", busy, 0);

        // Asynchronous reset while in WAIT
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 8'h01; cmd_b = 8'h02;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rw_in_wait", alu_in_sel, 3'b100);
        #2 rst = 1'b0;
        #1 check_reset("rst_wait");
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rw_no_rsp", rsp_valid, 0);
            check("rw_idle", busy, 0);
        end
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'h0F; cmd_b = 8'hF0;
        tick();
        cmd_valid = 1'b0;
        wait_rsp(10, waited);
        check("rw_new_data", rsp_data, 8'hFF);
        check("rw_new_op", rsp_op, 3'd2);
        handshake();

`ifdef ALU_SEQ_STATS_EN
        check("stats_start", rsp_count, 8'd1);
        for (int i = 0; i < 300; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'd7;
            tick();
            cmd_valid = 1'b0;
            wait_rsp(8, waited);
            handshake();
        end
        check("stats_saturate", rsp_count, 8'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
